// File: rtl/nn_pkg.sv
// Shared neural-processor constants: default data width, signed limits, saturation modes.
// Pure declarations; no timing or flow-control content.
package nn_pkg;

  localparam int DATA_WIDTH = 16;

  // Selects how the accumulator handles overflow.
  localparam bit SAT_WRAP  = 1'b0;
  localparam bit SAT_CLAMP = 1'b1;

  localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/mac_sat_add.sv
// Combinational signed add of accumulator and full-precision product, wrapped or clamped.
// Zero latency; no flow control.
module mac_sat_add
  import nn_pkg::*;
#(
  parameter int WIDTH    = DATA_WIDTH,
  parameter bit SATURATE = SAT_WRAP
) (
  input  logic [WIDTH-1:0]   acc,
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   result
);

  // Signed limits expressed at the full sum width so comparisons are exact.
  localparam logic signed [2*WIDTH:0] SUM_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH:0] SUM_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH:0] sum;

  assign sum = $signed({{(WIDTH+1){acc[WIDTH-1]}}, acc}) +
               $signed({prod[2*WIDTH-1], prod});

  always_comb begin
    result = sum[WIDTH-1:0];
    if (SATURATE == SAT_CLAMP) begin
      if (sum > SUM_MAX) begin
        result = SUM_MAX[WIDTH-1:0];
      end else if (sum < SUM_MIN) begin
        result = SUM_MIN[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mac_unit.sv
// Signed multiply-accumulate cell: acc <= acc + in*w every edge, out driven from acc.
// One-cycle latency, one MAC per cycle; no backpressure, only rstb clears the accumulator.
module mac_unit
  import nn_pkg::*;
#(
  parameter int WIDTH    = DATA_WIDTH,
  parameter bit SATURATE = SAT_WRAP
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0] prod;

  assign prod = $signed(in) * $signed(w);

  mac_sat_add #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc    (acc),
    .prod   (prod),
    .result (acc_nxt)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

  assign out = acc;

endmodule

// File: tb/tb_mac_unit.sv
// Directed and random checks of mac_unit, wrapping and saturating instances side by side.
module tb_mac_unit;

  localparam int W = 16;

  logic         clk;
  logic         rstb;
  logic [W-1:0] in_v;
  logic [W-1:0] w_v;
  logic [W-1:0] out_wrap;
  logic [W-1:0] out_sat;

  int n_tests;
  int n_fail;

  mac_unit #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk  (clk),
    .rstb (rstb),
    .in   (in_v),
    .w    (w_v),
    .out  (out_wrap)
  );

  mac_unit #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk  (clk),
    .rstb (rstb),
    .in   (in_v),
    .w    (w_v),
    .out  (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = v;
    return int'(s);
  endfunction

  // Drive a pair on the falling edge, then settle 1 ns past the next rising edge.
  task automatic apply(input int a, input int b);
    @(negedge clk);
    in_v = W'(a);
    w_v  = W'(b);
    @(posedge clk);
    #1;
  endtask

  // Must be called 1 ns after a rising edge so the pulse lands while clk is high.
  task automatic reset_pulse(input string tag);
    rstb = 1'b0;
    #1;
    check_eq({tag, "_wrap"}, sx(out_wrap), 0);
    check_eq({tag, "_sat"},  sx(out_sat),  0);
    #1;
    rstb = 1'b1;
  endtask

  int seq_in [8] = '{1, 4, 7, -2, 3, -5, 2, 3};
  int seq_w  [8] = '{4, -3, 2, -1, 2, 1, -5, 7};
  int seq_exp[8] = '{4, -8, 6, 8, 14, 9, -1, 20};

  initial begin
    longint sum;
    int     ref_w;
    int     ref_s;
    int     a;
    int     b;
    logic [W-1:0] trunc;

    n_tests = 0;
    n_fail  = 0;
    rstb = 1'b1;
    in_v = '0;
    w_v  = '0;

    // Power-up reset
    #2 rstb = 1'b0;
    #1;
    check_eq("por_wrap", sx(out_wrap), 0);
    check_eq("por_sat",  sx(out_sat),  0);

    // Short async pulse with clk high, then idle edges
    @(posedge clk);
    #1;
    reset_pulse("rst_async");
    for (int i = 0; i < 3; i++) begin
      apply(0, 0);
      check_eq("rst_idle", sx(out_wrap), 0);
    end

    // Accumulate sequence
    for (int i = 0; i < 8; i++) begin
      apply(seq_in[i], seq_w[i]);
      check_eq("seq_wrap", sx(out_wrap), seq_exp[i]);
      check_eq("seq_sat",  sx(out_sat),  seq_exp[i]);
    end

    // Hold with zero operands
    for (int i = 0; i < 3; i++) begin
      apply(0, 0);
      check_eq("hold", sx(out_wrap), 20);
      check_eq("hold_sat", sx(out_sat), 20);
    end
    apply(5, 0);
    check_eq("zero_w", sx(out_wrap), 20);

    // Mid-run reset after out reaches 14
    reset_pulse("rst_pre");
    for (int i = 0; i < 5; i++) apply(seq_in[i], seq_w[i]);
    check_eq("mid_pre", sx(out_wrap), 14);
    #1;
    reset_pulse("rst_mid");
    apply(-5, 1);
    check_eq("mid_post_wrap", sx(out_wrap), -5);
    check_eq("mid_post_sat",  sx(out_sat),  -5);

    // Positive overflow: build 32767 then add 1
    reset_pulse("rst_ovf");
    apply(181, 181);
    apply(1, 6);
    check_eq("max_wrap", sx(out_wrap), 32767);
    check_eq("max_sat",  sx(out_sat),  32767);
    apply(1, 1);
    check_eq("ovf_wrap", sx(out_wrap), -32768);
    check_eq("ovf_sat",  sx(out_sat),  32767);

    // Most-negative squared from zero
    reset_pulse("rst_sq");
    apply(-32768, -32768);
    check_eq("sq_wrap", sx(out_wrap), 0);
    check_eq("sq_sat",  sx(out_sat),  32767);

    // Negative overflow
    reset_pulse("rst_neg");
    apply(-32768, 1);
    check_eq("min_wrap", sx(out_wrap), -32768);
    check_eq("min_sat",  sx(out_sat),  -32768);
    apply(-1, 1);
    check_eq("unf_wrap", sx(out_wrap), 32767);
    check_eq("unf_sat",  sx(out_sat),  -32768);

    // Random pairs against wrapping and clamping reference models
    reset_pulse("rst_rand");
    ref_w = 0;
    ref_s = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) begin
        a = int'($urandom_range(0, 400)) - 200;
        b = int'($urandom_range(0, 400)) - 200;
      end else begin
        a = int'($urandom_range(0, 65535)) - 32768;
        b = int'($urandom_range(0, 65535)) - 32768;
      end
      apply(a, b);
      sum   = longint'(ref_w) + longint'(a) * longint'(b);
      trunc = sum[W-1:0];
      ref_w = sx(trunc);
      sum   = longint'(ref_s) + longint'(a) * longint'(b);
      if (sum > 32767) ref_s = 32767;
      else if (sum < -32768) ref_s = -32768;
      else ref_s = int'(sum);
      check_eq("rand_wrap", sx(out_wrap), ref_w);
      check_eq("rand_sat",  sx(out_sat),  ref_s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
